sum_requantizer: RTL and testbench
==================================

Name: sum_requantizer

Overview:
- Consumer end of the 19-bit signed add path. Accepts the widened 20-bit signed sums from the adders and narrows them back to the 19-bit neuron datapath width.
- Narrowing is arithmetic right shift with round-half-up, then saturation to the output width.
- Streaming valid/ready interface with a 2-stage pipeline and full throughput. Saturation events are counted for training/debug readback.

Parameters:
- IN_W, 20, signed input sum width
- OUT_W, 19, signed output width
- SHIFT, 1, arithmetic right-shift amount, range 0..IN_W-1
- CNT_W, 16, saturation event counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sum valid
- s_ready  out  1  block can accept input this cycle
- s_data  in  IN_W  signed sum
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts output
- m_data  out  OUT_W  signed requantized value
- m_sat  out  1  m_data was clipped; qualified by m_valid
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  CNT_W  number of saturated outputs accepted, sticky at max

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low, on rst_n. While rst_n=0:
  - all pipeline valids are 0, so m_valid=0
  - m_data=0, m_sat=0, sat_count=0
  - s_ready=0
  - s_ready becomes 1 on the first clock after release.
- Handshake:
  - Transfer in when s_valid&&s_ready; transfer out when m_valid&&m_ready.
  - m_valid, m_data and m_sat must hold stable while m_valid&&!m_ready.
  - s_ready must not depend combinationally on s_valid.
- Pipeline, two registered stages (v1, v2):
  - adv2 = !v2 || m_ready
  - adv1 = !v1 || adv2
  - s_ready = adv1
  - Stage 1 (shift and round): r = (s_data sign-extended to IN_W+1 bits + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. The extra bit means the rounding add can never overflow.
  - Stage 2 (saturate): if r > 2^(OUT_W-1)-1 then m_data = 2^(OUT_W-1)-1 and m_sat=1. If r < -2^(OUT_W-1) then m_data = -2^(OUT_W-1) and m_sat=1. Otherwise m_data = r[OUT_W-1:0] and m_sat=0.
- Latency and throughput:
  - Latency is 2 cycles from input accept to m_valid, assuming no stall.
  - With m_ready held at 1, one result is produced per cycle.
  - Results stay in order; none are dropped or duplicated.
- Stalls: if m_ready=0 with both stages full, s_ready=0 in that same cycle.
- Bubbles: if v1=0 and v2=1 with m_ready=0, one more input may still enter stage 1.
- Saturation counter:
  - sat_count increments on each output transfer with m_sat=1, and holds at 2^CNT_W-1.
  - If sat_clr and a counted transfer occur in the same cycle, sat_clr wins and sat_count=0.
- Reset mid-operation: in-flight data is discarded and nothing is emitted after reset release.
- SHIFT=0: no rounding term is added; the block is a pure saturating narrow.

Decomposition:
- Shared package nn_fixed_pkg holds:
  - NEURON_W=19 and SUM_W=20
  - typedefs neuron_t (signed [NEURON_W-1:0]) and sum_t (signed [SUM_W-1:0])
  - saturation limit constants NEURON_MAX and NEURON_MIN
- One sub-module: sat_narrow, the combinational saturating clip used in stage 2. It is reusable wherever the team narrows widths elsewhere.

Test Plan (defaults: SHIFT=1, OUT_W=19):
- Reset release with s_valid=1, s_data=5 → s_ready=0 during reset. After release the input is accepted; 2 cycles later m_data=3, m_sat=0.
- Rounding of negatives: s_data=-5 then -524288 → m_data=-2 then -262144, both with m_sat=0.
- Positive saturation: s_data=524287 → m_data=262143, m_sat=1, sat_count=1.
- Back-to-back with backpressure:
  - Send 1,2,3,4,5 on consecutive cycles. Hold m_ready=0 from cycle 3 to cycle 6.
  - s_ready falls once both stages are full. m_data holds stable throughout.
  - After release, outputs are 1,1,2,2,3 in order with no loss.
- Counter edge cases:
  - Force sat_count to max by 65535 saturating transfers plus 1 more → stays at 65535.
  - Assert sat_clr in the same cycle as a saturating transfer → sat_count=0.
- Mid-operation reset: pulse rst_n low while v1=v2=1 → m_valid=0 immediately. No stale output appears after release.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - shared fixed-point widths, types and saturation limits for the neuron datapath
//
// Purpose: single source of the neuron datapath widths so that adders,
// requantizers and neuron cores agree on the number formats.
//   NEURON_W / neuron_t : signed neuron value
//   SUM_W    / sum_t    : signed widened adder sum (one guard bit)
//   NEURON_MAX / NEURON_MIN : clip limits of neuron_t
package nn_fixed_pkg;

    localparam int NEURON_W = 19;
    localparam int SUM_W    = 20;

    typedef logic signed [NEURON_W-1:0] neuron_t;
    typedef logic signed [SUM_W-1:0]    sum_t;

    localparam neuron_t NEURON_MAX = {1'b0, {(NEURON_W-1){1'b1}}};
    localparam neuron_t NEURON_MIN = {1'b1, {(NEURON_W-1){1'b0}}};

endpackage

// File: rtl/sat_narrow.sv
// rtl/sat_narrow.sv - combinational saturating narrow of a signed value
//
// Purpose: clip a signed IN_W-bit value into a signed OUT_W-bit range.
// Requires IN_W > OUT_W.
// Ports:
//   din  in  IN_W   signed value to narrow
//   dout out OUT_W  clipped value
//   sat  out 1      din was outside the OUT_W range
module sat_narrow #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 19
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    // The value fits exactly when every bit from the output sign bit
    // upwards is a copy of the input sign.
    localparam int HI = IN_W - OUT_W + 1;

    logic [HI-1:0] top;

    assign top = din[IN_W-1:OUT_W-1];

    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (top != {HI{1'b0}} && top != {HI{1'b1}}) begin
            sat  = 1'b1;
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/sum_requantizer.sv
// rtl/sum_requantizer.sv - round, shift and saturate widened sums back to neuron width
//
// Purpose: two-stage streaming requantizer. Stage 1 does an arithmetic
// right shift with round-half-up, stage 2 saturates to OUT_W. Saturated
// outputs accepted downstream are counted in sat_count (sticky at max).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   input sum stream
//   m_valid/m_ready/m_data   output stream, m_sat flags a clipped m_data
//   sat_clr             synchronous clear of sat_count (wins over increment)
//   sat_count           saturated output transfers seen
module sum_requantizer
    import nn_fixed_pkg::*;
#(
    parameter int IN_W  = SUM_W,
    parameter int OUT_W = NEURON_W,
    parameter int SHIFT = 1,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_sat,
    input  logic                    sat_clr,
    output logic [CNT_W-1:0]        sat_count
);

    // One extra bit so the rounding add can never overflow.
    localparam int RW = IN_W + 1;
    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                    run;
    logic                    v1, v2;
    logic signed [RW-1:0]    r1;
    logic signed [OUT_W-1:0] d2;
    logic                    sat2;
    logic [CNT_W-1:0]        cnt;

    logic                    adv1, adv2;
    logic signed [RW-1:0]    ext, sum1, r_next;
    logic signed [OUT_W-1:0] n_data;
    logic                    n_sat;
    logic                    take_in;

    assign adv2    = !v2 || m_ready;
    assign adv1    = !v1 || adv2;
    // run keeps s_ready low during reset and for the first edge after it.
    assign s_ready = adv1 && run;
    assign take_in = s_valid && s_ready;

    assign ext    = {s_data[IN_W-1], s_data};
    assign sum1   = ext + RND;
    assign r_next = sum1 >>> SHIFT;

    sat_narrow #(
        .IN_W  (RW),
        .OUT_W (OUT_W)
    ) u_sat (
        .din  (r1),
        .dout (n_data),
        .sat  (n_sat)
    );

    assign m_valid   = v2;
    assign m_data    = d2;
    assign m_sat     = sat2;
    assign sat_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            v1   <= 1'b0;
            r1   <= '0;
            v2   <= 1'b0;
            d2   <= '0;
            sat2 <= 1'b0;
            cnt  <= '0;
        end else begin
            run <= 1'b1;

            if (adv1) begin
                v1 <= take_in;
                if (take_in) begin
                    r1 <= r_next;
                end
            end

            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    d2   <= n_data;
                    sat2 <= n_sat;
                end
            end

            if (sat_clr) begin
                cnt <= '0;
            end else if (v2 && m_ready && sat2 && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_requantizer.sv
// tb/tb_sum_requantizer.sv - directed self-checking bench for sum_requantizer
module tb_sum_requantizer;
    import nn_fixed_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    sum_t        s_data;
    logic        m_valid;
    logic        m_ready;
    neuron_t     m_data;
    logic        m_sat;
    logic        sat_clr;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    sum_requantizer #(
        .IN_W  (20),
        .OUT_W (19),
        .SHIFT (1),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sat     (m_sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 20'sd5;
        m_ready = 1'b1;
        sat_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b want 0", s_ready); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++;
        if (m_data !== 19'sd0 || m_sat !== 1'b0) begin
            errors++; $display("FAIL reset_m_data got %0d/%0b want 0/0", m_data, m_sat);
        end
        checks++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count got %0d want 0", sat_count); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready got %0b want 1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL release_early_valid got %0b want 0", m_valid); end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 19'sd3 || m_sat !== 1'b0) begin
            errors++;
            $display("FAIL release_first_out got v=%0b d=%0d s=%0b want v=1 d=3 s=0", m_valid, m_data, m_sat);
        end
        @(negedge clk);
    endtask

    task automatic test_round_neg;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = -20'sd5;
        @(negedge clk);
        s_data  = -20'sd524288;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== -19'sd2 || m_sat !== 1'b0) begin
            errors++;
            $display("FAIL round_neg5 got v=%0b d=%0d s=%0b want v=1 d=-2 s=0", m_valid, m_data, m_sat);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== -19'sd262144 || m_sat !== 1'b0) begin
            errors++;
            $display("FAIL round_negmin got v=%0b d=%0d s=%0b want v=1 d=-262144 s=0", m_valid, m_data, m_sat);
        end
        @(negedge clk);
    endtask

    task automatic test_pos_sat;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 20'sd524287;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 19'sd262143 || m_sat !== 1'b1) begin
            errors++;
            $display("FAIL pos_sat got v=%0b d=%0d s=%0b want v=1 d=262143 s=1", m_valid, m_data, m_sat);
        end
        @(negedge clk);
        checks++;
        if (sat_count !== 16'd1) begin errors++; $display("FAIL pos_sat_count got %0d want 1", sat_count); end
    endtask

    task automatic test_back_to_back;
        neuron_t exp_out [5];
        int idx  = 0;
        int outn = 0;
        exp_out[0] = 19'sd1;
        exp_out[1] = 19'sd1;
        exp_out[2] = 19'sd2;
        exp_out[3] = 19'sd2;
        exp_out[4] = 19'sd3;
        for (int cyc = 0; cyc < 40 && outn < 5; cyc++) begin
            m_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 5) begin
                s_valid = 1'b1;
                s_data  = 20'(idx + 1);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (cyc == 3) begin
                checks++;
                if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready_full got %0b want 0", s_ready); end
            end
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 19'sd1) begin
                    errors++;
                    $display("FAIL b2b_stall_hold cyc %0d got v=%0b d=%0d want v=1 d=1", cyc, m_valid, m_data);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== exp_out[outn]) begin
                    errors++;
                    $display("FAIL b2b_out%0d got %0d want %0d", outn, m_data, exp_out[outn]);
                end
                outn++;
            end
            if (s_valid && s_ready) idx++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (outn != 5 || idx != 5) begin
            errors++; $display("FAIL b2b_count got out=%0d in=%0d want 5/5", outn, idx);
        end
        @(negedge clk);
    endtask

    task automatic test_counter;
        int seen = 0;
        m_ready = 1'b1;
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        checks++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", sat_count); end
        s_valid = 1'b1;
        s_data  = 20'sd524287;
        for (int i = 0; i < 65535; i++) @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sat_count !== 16'd65535) begin errors++; $display("FAIL cnt_reach_max got %0d want 65535", sat_count); end
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sat_count !== 16'd65535) begin errors++; $display("FAIL cnt_sticky got %0d want 65535", sat_count); end
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (m_valid && m_ready && m_sat) begin
                sat_clr = 1'b1;
                seen = 1;
            end
            @(negedge clk);
        end
        sat_clr = 1'b0;
        checks++;
        if (seen == 0 || sat_count !== 16'd0) begin
            errors++; $display("FAIL cnt_clr_wins got %0d (seen %0d) want 0", sat_count, seen);
        end
    endtask

    task automatic test_mid_reset;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 20'sd7;
        @(negedge clk);
        s_data  = 20'sd9;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full got v=%0b r=%0b want v=1 r=0", m_valid, s_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b want 0", m_valid); end
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cyc %0d got %0b want 0", i, m_valid); end
        end
        checks++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL mid_sat_count got %0d want 0", sat_count); end
    endtask

    initial begin
        test_reset();
        test_round_neg();
        test_pos_sat();
        test_back_to_back();
        test_counter();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
